// File: rtl/slowmem_cache_ctrl_pkg.sv
// ============================================================================
// Module  : slowmem_cache_ctrl_pkg
// Brief   : Shared widths, state encodings and geometry helpers for the
//           slowmem cache controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package slowmem_cache_ctrl_pkg;

    localparam int c_word_w           = 16;
    localparam int c_addr_w           = 16;
    localparam int c_memdelay_default = 4;

    typedef logic [2:0] state_t;

    localparam state_t c_st_idle    = 3'd0;
    localparam state_t c_st_rstrobe = 3'd1;
    localparam state_t c_st_rwait   = 3'd2;
    localparam state_t c_st_wstrobe = 3'd3;
    localparam state_t c_st_done    = 3'd4;

    // LINES must be a power of two and at least 2.
    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int lines);
        return c_addr_w - $clog2(lines);
    endfunction

endpackage

`default_nettype wire

// File: rtl/slowmem_cache_ctrl_cache_array.sv
// ============================================================================
// Module  : cache_array
// Brief   : Direct-mapped valid/tag/data store with one write port and a
//           combinational lookup.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_array
    import slowmem_cache_ctrl_pkg::*;
#(
    parameter int LINES = 8
) (
    input  logic                clk,
    input  logic                i_clear,
    input  logic                i_wr_en,
    input  logic [c_addr_w-1:0] i_wr_addr,
    input  logic [c_word_w-1:0] i_wr_data,
    input  logic [c_addr_w-1:0] i_lk_addr,
    output logic                o_hit,
    output logic [c_word_w-1:0] o_data
);

    localparam int c_idx_w = idx_w(LINES);
    localparam int c_tag_w = tag_w(LINES);

    logic [c_idx_w-1:0] w_wr_idx;
    logic [c_tag_w-1:0] w_wr_tag;
    logic [c_idx_w-1:0] w_lk_idx;
    logic [c_tag_w-1:0] w_lk_tag;

    logic [LINES-1:0]    w_valid;
    logic [c_tag_w-1:0]  w_tag  [LINES];
    logic [c_word_w-1:0] w_data [LINES];

    assign w_wr_idx = i_wr_addr[c_idx_w-1:0];
    assign w_wr_tag = i_wr_addr[c_addr_w-1:c_idx_w];
    assign w_lk_idx = i_lk_addr[c_idx_w-1:0];
    assign w_lk_tag = i_lk_addr[c_addr_w-1:c_idx_w];

    for (genvar i = 0; i < LINES; i++) begin : g_line
        logic                valid_d, valid_q;
        logic [c_tag_w-1:0]  tag_d, tag_q;
        logic [c_word_w-1:0] data_d, data_q;

        always_comb begin
            valid_d = valid_q;
            tag_d   = tag_q;
            data_d  = data_q;
            if (i_clear) begin
                valid_d = 1'b0;
            end else if (i_wr_en && (w_wr_idx == c_idx_w'(i))) begin
                valid_d = 1'b1;
                tag_d   = w_wr_tag;
                data_d  = i_wr_data;
            end
        end

        always_ff @(posedge clk) begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end

        assign w_valid[i] = valid_q;
        assign w_tag[i]   = tag_q;
        assign w_data[i]  = data_q;
    end

    assign o_hit  = w_valid[w_lk_idx] && (w_tag[w_lk_idx] == w_lk_tag);
    assign o_data = w_data[w_lk_idx];

endmodule

`default_nettype wire

// File: rtl/slowmem_cache_ctrl.sv
// ============================================================================
// Module  : slowmem_cache_ctrl
// Brief   : Write-through, no-write-allocate direct-mapped cache in front of
//           the slowmem strobe/mfc memory.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module slowmem_cache_ctrl
    import slowmem_cache_ctrl_pkg::*;
#(
    parameter int LINES    = 8,
    parameter int MEMDELAY = c_memdelay_default,
    parameter int TIMEOUT  = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_req,
    input  logic                cpu_rnotw,
    input  logic [c_addr_w-1:0] cpu_addr,
    input  logic [c_word_w-1:0] cpu_wdata,
    output logic                cpu_ready,
    output logic [c_word_w-1:0] cpu_rdata,
    output logic                strobe,
    output logic                rnotw,
    output logic [c_addr_w-1:0] addr,
    output logic [c_word_w-1:0] wdata,
    input  logic                mfc,
    input  logic [c_word_w-1:0] rdata,
    output logic [15:0]         hit_count,
    output logic [15:0]         miss_count
);

    localparam int c_cnt_max = (TIMEOUT > MEMDELAY) ? TIMEOUT : MEMDELAY;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    state_t               state_d, state_q;
    logic [c_cnt_w-1:0]   cnt_d, cnt_q;
    logic                 strobe_d, strobe_q;
    logic                 rnotw_d, rnotw_q;
    logic [c_addr_w-1:0]  addr_d, addr_q;
    logic [c_word_w-1:0]  wdata_d, wdata_q;
    logic                 cpu_ready_d, cpu_ready_q;
    logic [c_word_w-1:0]  cpu_rdata_d, cpu_rdata_q;
    logic [15:0]          hit_cnt_d, hit_cnt_q;
    logic [15:0]          miss_cnt_d, miss_cnt_q;

    logic                 w_lk_hit;
    logic [c_word_w-1:0]  w_lk_data;
    logic [c_addr_w-1:0]  w_lk_addr;
    logic                 w_wr_en;
    logic [c_word_w-1:0]  w_wr_data;
    logic [c_cnt_w-1:0]   w_cnt_inc;
    logic                 w_mfc_ok;
    logic                 w_timeout;

    // The CPU address is only looked up while idle; afterwards the latched
    // memory address identifies the line to fill or update.
    assign w_lk_addr = (state_q == c_st_idle) ? cpu_addr : addr_q;
    assign w_wr_data = (state_q == c_st_rwait) ? rdata : wdata_q;
    assign w_cnt_inc = cnt_q + c_cnt_w'(1);
    // mfc still asserted from an earlier or abandoned read is ignored until
    // the memory could genuinely have answered this strobe.
    assign w_mfc_ok  = mfc && (cnt_q >= c_cnt_w'(MEMDELAY));
    assign w_timeout = (w_cnt_inc == c_cnt_w'(TIMEOUT));

    cache_array #(
        .LINES (LINES)
    ) u_cache_array (
        .clk       (clk),
        .i_clear   (~reset),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (addr_q),
        .i_wr_data (w_wr_data),
        .i_lk_addr (w_lk_addr),
        .o_hit     (w_lk_hit),
        .o_data    (w_lk_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= c_st_idle;
            cnt_q       <= '0;
            strobe_q    <= 1'b0;
            rnotw_q     <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            strobe_q    <= strobe_d;
            rnotw_q     <= rnotw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle: begin
                if (cpu_req) begin
                    if (!cpu_rnotw)    state_d = c_st_wstrobe;
                    else if (w_lk_hit) state_d = c_st_done;
                    else               state_d = c_st_rstrobe;
                end
            end
            c_st_rstrobe: state_d = c_st_rwait;
            c_st_rwait: begin
                if (w_mfc_ok)       state_d = c_st_done;
                else if (w_timeout) state_d = c_st_rstrobe;
            end
            c_st_wstrobe: state_d = c_st_done;
            c_st_done:    state_d = c_st_idle;
            default:      state_d = c_st_idle;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        strobe_d    = 1'b0;
        rnotw_d     = rnotw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_ready_d = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        w_wr_en     = 1'b0;
        case (state_q)
            c_st_idle: begin
                if (cpu_req && cpu_rnotw && w_lk_hit) begin
                    cpu_rdata_d = w_lk_data;
                    cpu_ready_d = 1'b1;
                    if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
                end else if (cpu_req && cpu_rnotw) begin
                    if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
                    addr_d   = cpu_addr;
                    rnotw_d  = 1'b1;
                    strobe_d = 1'b1;
                end else if (cpu_req) begin
                    addr_d   = cpu_addr;
                    wdata_d  = cpu_wdata;
                    rnotw_d  = 1'b0;
                    strobe_d = 1'b1;
                end
            end
            c_st_rstrobe: begin
                cnt_d = '0;
            end
            c_st_rwait: begin
                cnt_d = w_cnt_inc;
                if (w_mfc_ok) begin
                    w_wr_en     = 1'b1;
                    cpu_rdata_d = rdata;
                    cpu_ready_d = 1'b1;
                end else if (w_timeout) begin
                    strobe_d = 1'b1;
                end
            end
            c_st_wstrobe: begin
                rnotw_d     = 1'b1;
                w_wr_en     = w_lk_hit;
                cpu_ready_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign cpu_ready  = cpu_ready_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign strobe     = strobe_q;
    assign rnotw      = rnotw_q;
    assign addr       = addr_q;
    assign wdata      = wdata_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule

`default_nettype wire

// File: doc/slowmem_cache_ctrl.md
Name: slowmem_cache_ctrl

Overview:
- Initiator-side controller for the `slowmem` strobe/mfc protocol.
- Sits between the processor's instruction/data fetch and `slowmem`.
- Provides a direct-mapped, write-through, no-write-allocate cache with a req/ready handshake toward the processor.
- Owns all strobe timing, including MEMDELAY counting and masking of stale mfc.

Parameters:
- LINES, 8, cache lines (power of two); index = addr[log2(LINES)-1:0], tag = remaining upper address bits.
- MEMDELAY, 4, slowmem read latency in cycles; must match the memory instance.
- TIMEOUT, 32, RWAIT cycles without a valid mfc before the read is re-strobed.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-low reset.
- cpu_req  in  1  request valid; held until cpu_ready.
- cpu_rnotw  in  1  1 = read, 0 = write.
- cpu_addr  in  16  word address.
- cpu_wdata  in  16  write data.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  16  read data, valid while cpu_ready=1.
- strobe  out  1  memory request pulse.
- rnotw  out  1  memory direction.
- addr  out  16  memory address.
- wdata  out  16  memory write data.
- mfc  in  1  memory function complete.
- rdata  in  16  memory read data.
- hit_count  out  16  saturating read-hit counter.
- miss_count  out  16  saturating read-miss counter.

Behaviour:
- Reset (reset==0 at posedge):
  - state = IDLE; all valid bits = 0.
  - strobe = 0, rnotw = 1, addr = 0, wdata = 0.
  - cpu_ready = 0, cpu_rdata = 0, wait counter = 0, hit_count = miss_count = 0.
  - Reset mid-operation abandons the access with no memory write. A later stale mfc is masked (see RWAIT).
- All outputs are registered.
- States: IDLE, RSTROBE, RWAIT, WSTROBE, DONE.
- IDLE, cpu_req=1, read hit (valid && tag match):
  - cpu_rdata <= line data, cpu_ready <= 1, hit_count++, go to DONE.
  - Latency: ready is visible in the cycle after req is sampled.
- IDLE, read miss:
  - miss_count++; addr <= cpu_addr, rnotw <= 1, strobe <= 1; go to RSTROBE.
- RSTROBE:
  - strobe <= 0, wait counter <= 0, go to RWAIT.
- RWAIT:
  - Counter increments each cycle.
  - mfc is honoured only when counter >= MEMDELAY. A held-over mfc=1 from an earlier or abandoned read is ignored.
  - On valid mfc: fill line (valid=1, tag, data=rdata), cpu_rdata <= rdata, cpu_ready <= 1, go to DONE.
  - If counter reaches TIMEOUT: reissue strobe, go to RSTROBE.
  - Read-miss latency with MEMDELAY=4: cpu_ready is high 7 cycles after req is sampled.
- IDLE, write:
  - addr <= cpu_addr, wdata <= cpu_wdata, rnotw <= 0, strobe <= 1; go to WSTROBE.
- WSTROBE:
  - Memory performs the write at this edge.
  - strobe <= 0, rnotw <= 1.
  - On a hit, update line data; on a miss, no allocation.
  - cpu_ready <= 1, go to DONE.
- DONE:
  - cpu_ready <= 0, strobe stays 0, cpu_req ignored, go to IDLE.
  - This guaranteed strobe-free cycle lets slowmem clear mfc before the next request.
- Only one outstanding memory access at a time.
- strobe is never high for two consecutive cycles.
- Counters saturate at 16'hFFFF.
- Tag comparison uses the full upper address bits; there is no aliasing.

Decomposition:
- Shared package holds:
  - WORD width and MEMDELAY default.
  - State encodings IDLE/RSTROBE/RWAIT/WSTROBE/DONE.
  - Index/tag width functions of LINES.
- Sub-module `cache_array`: valid/tag/data storage.
  - Inputs: synchronous clear, write port (fill or update).
  - Output: combinational lookup returning hit and data.
- The FSM and counters stay in the top block.

Test Plan:
- Read miss then hit: mem[0x0013]=0xBEEF; read 0x0013 -> one strobe with rnotw=1, addr=0x0013; cpu_ready 7 cycles after accept with 0xBEEF. Repeat read -> ready next cycle, no strobe, hit_count=1, miss_count=1.
- Write hit/miss:
  - Cached 0x0013: write 0x1234 -> strobe with rnotw=0 and wdata=0x1234; following read hits with 0x1234.
  - Uncached 0x0020: write 0x5555 -> following read of 0x0020 misses and returns 0x5555.
- Conflict eviction: read 0x0003, then 0x000B (same index) -> both miss; re-read 0x0003 -> miss again, miss_count=3.
- Stale mfc: drive mfc=1 continuously from a memory model until the real completion -> controller does not complete before counter >= MEMDELAY; data correct.
- Reset mid-miss: reset low for one cycle, 2 cycles after strobe -> strobe=0, cpu_ready=0, all lines invalid. New read 0x0040 -> fresh strobe, correct data, no early completion.
- Timeout: memory model suppresses mfc -> strobe reissued after 32 RWAIT cycles; second attempt completes normally.
